erosion_stream_packer: RTL and testbench

EROSION_STREAM_PACKER -- requirements
Module: erosion_stream_packer

---
 rtl/erosion_pkg.sv | 20 ++
 rtl/erosion_stream_packer_if.sv | 27 ++
 rtl/packer_fifo.sv | 77 +++++++
 rtl/erosion_stream_packer.sv | 183 ++++++++++++++++++
 tb/tb_erosion_stream_packer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/erosion_pkg.sv
// Shared types and constants for the erosion stream packer.
// Pixel lanes per word, FIFO entry layout and FSM encoding.
package erosion_pkg;

  localparam int PIX_PER_WORD = 4;
  localparam int FIFO_W = 34;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } pk_state_e;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } word_t;

endpackage

// File: rtl/erosion_stream_packer_if.sv
// AXI4-Stream style word channel out of the erosion packer.
// master drives the word, slave drives tready.
interface erosion_stream_packer_if;

  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic        tuser;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/packer_fifo.sv
// Synchronous word FIFO with a registered head entry.
// level counts stored entries; full/empty derive from it.
module packer_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rd_nxt  = rd_ptr + 1'b1;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Head register tracks mem[rd_ptr], bypassing writes into an emptying FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      cnt_q <= cnt_d;
      valid <= (cnt_d != '0);
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end
      if (do_push && (empty || (do_pop && cnt_q == 1))) begin
        rdata <= wdata;
      end else if (do_pop && cnt_q > 1) begin
        rdata <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/erosion_stream_packer.sv
// Packs eroded pixels 4-per-word onto a stream with row/frame tags.
// EROSION_PACKER_STATS_EN enables the dropped_words counter.
module erosion_stream_packer
  import erosion_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic        sensor_state,
  input  logic        erosion_valid,
  input  logic [7:0]  erosion_dout,
  erosion_stream_packer_if.master m_axis,
  output logic        overflow,
  output logic        frame_done,
  output logic [15:0] dropped_words
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  pk_state_e     state_q;
  pk_state_e     state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [23:0]   word_q;
  logic          done_q;
  logic [1:0]    lane;
  logic          accept;
  logic          start;
  logic          last_col;
  logic          last_row;
  logic          word_end;
  logic          frame_end;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_valid;
  logic [LW-1:0] fifo_level;
  word_t         push_word;
  word_t         head;

  assign lane      = col_q[1:0];
  assign start     = (state_q == IDLE) && sensor_state;
  assign accept    = (state_q == RUN) && erosion_valid;
  assign last_col  = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row  = (row_q == RW'(IMG_HEIGHT - 1));
  assign word_end  = accept && (lane == 2'(PIX_PER_WORD - 1));
  assign frame_end = accept && last_col && last_row;
  assign pop       = fifo_valid && m_axis.tready;
  assign drop      = word_end && fifo_full && !pop;

  always_comb begin
    push_word      = '0;
    push_word.data = {erosion_dout, word_q};
    push_word.last = last_col;
    push_word.user = (row_q == '0) &&
                     (col_q == CW'(PIX_PER_WORD - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sensor_state) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (frame_end || !sensor_state) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Lanes 0..2 are held here; lane 3 goes straight into the FIFO
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      word_q <= '0;
    end else if (accept) begin
      unique case (1'b1)
        lane == 2'd0: word_q[7:0]   <= erosion_dout;
        lane == 2'd1: word_q[15:8]  <= erosion_dout;
        lane == 2'd2: word_q[23:16] <= erosion_dout;
        lane == 2'd3: word_q        <= word_q;
        default:      word_q        <= word_q;
      endcase
    end
  end

  // done_q marks that the frame's final word made it into the FIFO
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      done_q   <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      done_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (frame_end && !drop) begin
        done_q <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef EROSION_PACKER_STATS_EN
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      dropped_words <= '0;
    end else if (start) begin
      dropped_words <= '0;
    end else if (drop && dropped_words != 16'hFFFF) begin
      dropped_words <= dropped_words + 1'b1;
    end
  end
`else
  assign dropped_words = '0;
`endif

  assign frame_done = (state_q == DRAIN) && done_q && pop &&
                      (fifo_level == LW'(1));

  packer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (s_axi_aclk),
    .rst   (s_axi_areset),
    .push  (word_end),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .valid (fifo_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign m_axis.tvalid = fifo_valid;
  assign m_axis.tdata  = head.data;
  assign m_axis.tlast  = head.last;
  assign m_axis.tuser  = head.user;

endmodule

// File: tb/tb_erosion_stream_packer.sv
// Directed bench for erosion_stream_packer with a queue-level model.
// Honours EROSION_PACKER_STATS_EN for the dropped_words expectation.
module tb_erosion_stream_packer;
  import erosion_pkg::*;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int D  = 4;
  localparam int WB = 12;
`ifdef EROSION_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sensor;
  logic evalid;
  logic [7:0] edout;
  logic tready_a;
  logic tready_b;
  logic ovf_a, ovf_b, done_a, done_b;
  logic [15:0] drop_a, drop_b;

  erosion_stream_packer_if if_a ();
  erosion_stream_packer_if if_b ();
  assign if_a.tready = tready_a;
  assign if_b.tready = tready_b;

  erosion_stream_packer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)
  ) u_a (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .sensor_state(sensor), .erosion_valid(evalid),
    .erosion_dout(edout), .m_axis(if_a),
    .overflow(ovf_a), .frame_done(done_a),
    .dropped_words(drop_a)
  );

  erosion_stream_packer #(
    .IMG_WIDTH(WB), .IMG_HEIGHT(H), .FIFO_DEPTH(D)
  ) u_b (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .sensor_state(sensor), .erosion_valid(evalid),
    .erosion_dout(edout), .m_axis(if_b),
    .overflow(ovf_b), .frame_done(done_b),
    .dropped_words(drop_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  logic [33:0] got_a[$];
  logic [33:0] got_b[$];
  logic [33:0] exp_w[4];

  task automatic check(string name, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model: frame as a flat pixel index, FIFO as a bounded queue
  logic [33:0] m_q[$];
  int m_mode;
  int m_idx;
  int m_drop;
  bit m_ovf;
  bit m_cmp;
  bit m_pop;
  bit m_was_empty;
  logic [31:0] m_acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_mode = 0;
      m_idx = 0;
      m_drop = 0;
      m_ovf = 0;
      m_cmp = 0;
      m_acc = '0;
    end else begin
      m_pop = (m_q.size() != 0) && tready_a;
      m_was_empty = (m_q.size() == 0);
      if (m_pop) void'(m_q.pop_front());
      case (m_mode)
        0: if (sensor) begin
          m_mode = 1;
          m_idx = 0;
          m_drop = 0;
          m_ovf = 0;
          m_cmp = 0;
        end
        1: begin
          if (evalid) begin
            m_acc[8*(m_idx%4) +: 8] = edout;
            m_idx++;
            if (m_idx % 4 == 0) begin
              if (m_q.size() < D) begin
                m_q.push_back({m_idx == 4, m_idx % W == 0, m_acc});
                if (m_idx == W*H) m_cmp = 1;
              end else begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
              end
            end
          end
          if ((evalid && m_idx == W*H) || !sensor) m_mode = 2;
        end
        default: if (m_was_empty) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("tvalid", if_a.tvalid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("tdata", if_a.tdata, m_q[0][31:0]);
        check("tlast", if_a.tlast, m_q[0][32]);
        check("tuser", if_a.tuser, m_q[0][33]);
      end
      check("overflow", ovf_a, m_ovf);
      check("dropped", drop_a, STATS ? m_drop : 0);
      check("frame_done", done_a,
            m_mode == 2 && m_cmp && m_q.size() == 1 && tready_a);
      if (if_a.tvalid && tready_a)
        got_a.push_back({if_a.tuser, if_a.tlast, if_a.tdata});
      if (if_b.tvalid && tready_b)
        got_b.push_back({if_b.tuser, if_b.tlast, if_b.tdata});
      if (done_a) done_cnt++;
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    got_a.delete();
    got_b.delete();
    done_cnt = 0;
  endtask

  task automatic start_frame();
    sensor = 1'b1;
    idle(1);
  endtask

  task automatic send(int n, int base);
    for (int i = 0; i < n; i++) begin
      evalid = 1'b1;
      edout = 8'(base + i);
      idle(1);
    end
    evalid = 1'b0;
  endtask

  task automatic check_words(string name);
    check({name, "_count"}, got_a.size(), 4);
    for (int i = 0; i < 4 && i < got_a.size(); i++)
      check(name, got_a[i], exp_w[i]);
  endtask

  initial begin
    exp_w[0] = 34'h2_0302_0100;
    exp_w[1] = 34'h1_0706_0504;
    exp_w[2] = 34'h0_0B0A_0908;
    exp_w[3] = 34'h1_0F0E_0D0C;
    rst = 1'b1;
    sensor = 1'b0;
    evalid = 1'b0;
    edout = '0;
    tready_a = 1'b1;
    tready_b = 1'b1;
    idle(3);
    check("rst_tvalid", if_a.tvalid, 0);
    check("rst_tdata", if_a.tdata, 0);
    check("rst_tlast", if_a.tlast, 0);
    check("rst_tuser", if_a.tuser, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_done", done_a, 0);
    check("rst_drop", drop_a, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Bring-up
    do_reset();
    start_frame();
    send(16, 0);
    sensor = 1'b0;
    idle(10);
    check_words("bringup_word");
    check("bringup_done_cnt", done_cnt, 1);
    check("bringup_state", u_a.state_q, IDLE);

    // Backpressure for the whole frame
    do_reset();
    tready_a = 1'b0;
    start_frame();
    send(16, 0);
    sensor = 1'b0;
    idle(5);
    check("bp_tvalid", if_a.tvalid, 1);
    check("bp_tdata", if_a.tdata, 32'h0302_0100);
    check("bp_ovf", ovf_a, 0);
    tready_a = 1'b1;
    idle(10);
    check_words("bp_word");
    check("bp_done_cnt", done_cnt, 1);

    // Overflow on the 12-wide instance
    do_reset();
    tready_a = 1'b0;
    tready_b = 1'b0;
    start_frame();
    send(20, 0);
    sensor = 1'b0;
    idle(3);
    check("ovf_b_flag", ovf_b, 1);
    check("ovf_b_dropped", drop_b, STATS ? 1 : 0);
    check("ovf_b_tvalid", if_b.tvalid, 1);
    check("ovf_b_tdata", if_b.tdata, 32'h0302_0100);
    check("ovf_a_flag", ovf_a, 0);
    tready_a = 1'b1;
    tready_b = 1'b1;
    idle(10);
    check("ovf_b_count", got_b.size(), 4);
    if (got_b.size() == 4) begin
      check("ovf_b_w0", got_b[0], 34'h2_0302_0100);
      check("ovf_b_w1", got_b[1], 34'h0_0706_0504);
      check("ovf_b_w2", got_b[2], 34'h1_0B0A_0908);
      check("ovf_b_w3", got_b[3], 34'h0_0F0E_0D0C);
    end
    check("ovf_b_state", u_b.state_q, IDLE);

    // Abort after 6 pixels
    do_reset();
    start_frame();
    send(6, 0);
    sensor = 1'b0;
    idle(10);
    check("abort_count", got_a.size(), 1);
    if (got_a.size() > 0)
      check("abort_word", got_a[0], 34'h2_0302_0100);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_state", u_a.state_q, IDLE);

    // Asynchronous reset with two words queued
    do_reset();
    tready_a = 1'b0;
    start_frame();
    send(9, 0);
    check("arst_pre_tvalid", if_a.tvalid, 1);
    #2;
    rst = 1'b1;
    sensor = 1'b0;
    #1;
    check("arst_tvalid", if_a.tvalid, 0);
    check("arst_tdata", if_a.tdata, 0);
    idle(2);
    rst = 1'b0;
    tready_a = 1'b1;
    idle(8);
    check("arst_quiet", got_a.size(), 0);
    check("arst_state", u_a.state_q, IDLE);
    start_frame();
    send(16, 8'h40);
    sensor = 1'b0;
    idle(10);
    check("arst_new_count", got_a.size(), 4);
    if (got_a.size() > 0)
      check("arst_new_w0", got_a[0], 34'h2_4342_4140);
    check("arst_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
